fifo_rd_stream_40bit: RTL and testbench
=======================================

Name: fifo_rd_stream_40bit

Overview:
- Read-side adapter directly downstream of the 512x40 FIFO.
- Drives the FIFO pop strobe and absorbs the 1-cycle registered RAM read latency.
- Re-presents popped words as a valid/ready stream with a small local buffer, so consumers can stall freely without losing in-flight words.

Parameters:
DW, 40, data width; must match the FIFO data width.
DEPTH, 3, local buffer entries; legal range 2..4; DEPTH>=3 is required for 1 beat/cycle sustained.
CW, 16, width of the optional beat counter.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  synchronous, active-low reset (0 = reset).
clr  input  1  synchronous flush; driven in the same cycle as the FIFO clr.
fifo_empty  input  1  FIFO empty flag.
fifo_re  output  1  FIFO pop strobe.
fifo_dout  input  DW  FIFO read data; valid exactly 1 cycle after fifo_re.
out_valid  output  1  stream data valid.
out_ready  input  1  consumer ready.
out_data  output  DW  stream data (buffer head).
occupancy  output  3  buffered entries, 0..DEPTH (excludes the in-flight word).
beat_cnt  output  CW  accepted-beat count (present only with the macro).

Behaviour:
- State:
  - circular buffer of DEPTH x DW;
  - rd_ptr and wr_ptr, modulo DEPTH with explicit wrap at DEPTH-1 (DEPTH need not be a power of 2);
  - count, 0..DEPTH;
  - pend: 1-bit in-flight flag, pend <= fifo_re each cycle.
- fifo_re = rst & !clr & !fifo_empty & ((count + pend) < DEPTH).
  - Purely combinational from registers, fifo_empty and clr.
  - No path from out_ready to fifo_re.
- Capture: when pend=1, fifo_dout is written to buf[wr_ptr] and wr_ptr advances. No other qualifier applies.
- Credit rule guarantees a capture never finds the buffer full. An overflow is a design error and is asserted in simulation.
- out_valid = (count != 0); out_data = buf[rd_ptr].
- Pop: out_valid & out_ready advances rd_ptr.
- Count update per cycle: count + pend - pop. A simultaneous capture and pop leaves count unchanged.
- Latency: fifo_re high in cycle t -> word captured at end of t+1 -> out_valid high in t+2 (if the buffer was empty).
- Throughput:
  - DEPTH>=3 with out_ready held high sustains 1 word/cycle after the 2-cycle fill.
  - DEPTH=2 sustains 1 word per 2 cycles.
- Ordering is strict FIFO; no word is dropped or duplicated.
- Stall: with out_ready=0, out_data/out_valid stay stable until accepted. fifo_re stops once count+pend reaches DEPTH.
- Reset (rst=0 at a clock edge): count, ptrs and pend go to 0; all buffer entries go to 0.
  - Outputs after reset: out_valid=0, out_data=0, occupancy=0, fifo_re=0.
  - Reset mid-transfer discards any in-flight word.
- clr=1: same clearing as reset, except buffer contents are left unchanged.
  - fifo_re is forced to 0 in that cycle.
  - A word in flight from the previous cycle (pend=1) is discarded, not captured.
  - out_valid=0 from the next cycle.
- fifo_empty is only sampled for issuing fifo_re. A word written into the FIFO at edge t may be popped in cycle t+1.

Optional Feature:
- Macro: FIFO_RD_STREAM_BEAT_CNT_EN.
- Defined:
  - beat_cnt port exists; CW-bit counter increments on each out_valid & out_ready.
  - Wraps modulo 2^CW.
  - Cleared to 0 by rst=0 or clr=1; clr has priority over an increment in the same cycle.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset with rst=0 for 2 cycles, FIFO holding words -> fifo_re=0, out_valid=0, out_data=0, occupancy=0 throughout.
2. FIFO preloaded with 0x00_0000_0001..0x00_0000_0008, out_ready=1, DEPTH=3 -> first out_valid 2 cycles after first fifo_re; then 8 consecutive beats in order, 1/cycle; fifo_re deasserts when fifo_empty=1.
3. Same preload, out_ready=0 for 10 cycles, then 1 -> fifo_re stops after 3 pops, occupancy=3, out_data=0x..01 stable; afterwards all 8 words delivered in order with none lost.
4. out_ready toggled 1/0 every cycle over 20 words (random data) -> output sequence equals input sequence, and rd_ptr/wr_ptr wrap past DEPTH-1 correctly.
5. clr asserted while pend=1 and occupancy=2 -> next cycle out_valid=0, occupancy=0, in-flight word never appears; later new words stream normally.
6. FIFO_RD_STREAM_BEAT_CNT_EN defined, CW=4, 18 accepted beats -> beat_cnt=2; clr coinciding with an accepted beat -> beat_cnt=0.

Source files
------------

// File: rtl/fifo_rd_stream_40bit.sv
// Read-side adapter for the 512x40 FIFO: issues pops, absorbs the RAM read latency,
// and re-presents words as a valid/ready stream. Beat counter: FIFO_RD_STREAM_BEAT_CNT_EN.
module fifo_rd_stream_40bit #(
    parameter int DW    = 40,
    parameter int DEPTH = 3,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          fifo_empty,
    output logic          fifo_re,
    input  logic [DW-1:0] fifo_dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [2:0]    occupancy
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
    ,
    output logic [CW-1:0] beat_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [2:0] FULL = 3'(DEPTH);

    if (DEPTH < 2 || DEPTH > 4 || CW < 1) begin : g_bad_cfg
        $error("fifo_rd_stream_40bit: DEPTH must be 2..4 and CW >= 1");
    end

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [2:0]    count;
    logic          pend;
    logic          pop;

    assign out_valid = (count != 3'd0);
    assign out_data  = mem[rd_ptr];
    assign occupancy = count;
    assign pop       = out_valid & out_ready;

    // Credit counts the in-flight word so a capture always has a free slot.
    assign fifo_re = rst & ~clr & ~fifo_empty
                   & ((count + {2'b00, pend}) < FULL);

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pend   <= 1'b0;
            if (!rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end
        end else begin
            pend <= fifo_re;
            if (pend) begin
                mem[wr_ptr] <= fifo_dout;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + {2'b00, pend} - {2'b00, pop};
        end
    end

    overflow_chk: assert property (
        @(posedge clk) disable iff (!rst || clr)
        pend |-> (count < FULL)
    );

`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream_40bit.sv
// Bench for fifo_rd_stream_40bit: FIFO model with registered read data,
// scoreboard queue for stream ordering, per-cycle vector table for handshake timing.
module tb_fifo_rd_stream_40bit;

    localparam int DW    = 40;
    localparam int DEPTH = 3;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_re;
    logic [DW-1:0] fifo_dout = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [2:0]    occupancy;
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
    logic [CW-1:0] beat_cnt;
`endif

    always #5 clk = ~clk;

    fifo_rd_stream_40bit #(
        .DW(DW),
        .DEPTH(DEPTH),
        .CW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .fifo_empty(fifo_empty),
        .fifo_re(fifo_re),
        .fifo_dout(fifo_dout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .occupancy(occupancy)
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
        ,
        .beat_cnt(beat_cnt)
`endif
    );

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q  [$];
    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int beats  = 0;

    typedef struct {
        logic       rst;
        logic       rdy;
        logic       re;
        logic       vld;
        logic [2:0] occ;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock: handshake observed at negedge, FIFO read data lands after the edge.
    task automatic tick();
        logic re_s;
        @(negedge clk);
        re_s = fifo_re;
        if (out_valid && out_ready) begin
            beats++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_beat: got %0h, required no beat", out_data);
            end else begin
                chk("beat_data", out_data, exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
        if (re_s) begin
            pops++;
            if (fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
        end
        fifo_empty = (fifo_q.size() == 0);
        #1;
    endtask

    task automatic drain(input int budget, input bit toggle, input string name);
        for (int n = 0; n < budget && exp_q.size() != 0; n++) begin
            if (toggle) out_ready = ~out_ready;
            tick();
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w;

        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
        for (int i = 4; i < 10; i++) begin
            vecs[i] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd1};
        end
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd1};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0};

        // Reset with a loaded FIFO, then full-rate streaming of 1..8
        for (int i = 1; i <= 8; i++) push(DW'(i));
        rst = 1'b0;
        tick();
        for (int i = 0; i < 13; i++) begin
            rst = vecs[i].rst;
            out_ready = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d_fifo_re", i), fifo_re, vecs[i].re);
            chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].vld);
            chk($sformatf("v%0d_occupancy", i), occupancy, vecs[i].occ);
            if (!vecs[i].rst) chk($sformatf("v%0d_out_data", i), out_data, 0);
            tick();
        end
        chk("stream_left", exp_q.size(), 0);

        // Stall for 10 cycles: three pops, head held stable
        for (int i = 1; i <= 8; i++) push(DW'(i));
        out_ready = 1'b0;
        pops = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 1) chk("stall_data", out_data, 1);
        end
        chk("stall_pops", pops, 3);
        chk("stall_occ", occupancy, 3);
        chk("stall_re", fifo_re, 0);
        chk("stall_valid", out_valid, 1);
        out_ready = 1'b1;
        drain(40, 1'b0, "stall_drain");

        // Alternating ready over 20 random words
        beats = 0;
        for (int i = 0; i < 20; i++) begin
            w = DW'({$urandom(), $urandom()});
            push(w);
        end
        out_ready = 1'b0;
        drain(200, 1'b1, "toggle_drain");
        chk("toggle_beats", beats, 20);

        // Flush with a word in flight and two buffered
        reset_dut();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(DW'(40'h100 + i));
        tick();
        tick();
        tick();
        chk("pre_clr_occ", occupancy, 2);
        chk("pre_clr_re", fifo_re, 0);
        clr = 1'b1;
        #1;
        chk("clr_re", fifo_re, 0);
        tick();
        clr = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        #1;
        chk("clr_valid", out_valid, 0);
        chk("clr_occ", occupancy, 0);
        tick();
        chk("clr_occ_later", occupancy, 0);
        for (int i = 0; i < 4; i++) push(DW'(40'h200 + i));
        out_ready = 1'b1;
        drain(30, 1'b0, "clr_drain");

`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
        // Beat counter wraps at 2^CW and yields to clr
        reset_dut();
        chk("beat_reset", beat_cnt, 0);
        for (int i = 0; i < 18; i++) push(DW'(40'h300 + i));
        out_ready = 1'b1;
        drain(60, 1'b0, "beat_drain");
        chk("beat_wrap", beat_cnt, 2);
        for (int i = 0; i < 3; i++) push(DW'(40'h400 + i));
        for (int n = 0; n < 10 && !out_valid; n++) tick();
        chk("beat_wait_valid", out_valid, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        #1;
        chk("beat_clr", beat_cnt, 0);
        chk("beat_clr_valid", out_valid, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
